// File: rtl/posit_norm_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : posit_norm_pipe_if
// Brief    : Operation/result bus between adder core, normaliser and encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface posit_norm_pipe_if #(
  parameter int N     = 16,
  parameter int ES    = 2,
  parameter int TAG_W = 4
);
  localparam int BS = $clog2(N);
  localparam int MW = N - ES + 4;
  localparam int SW = BS + ES + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_sub;
  logic [SW-1:0]     in_scale;
  logic [MW-1:0]     in_c;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [MW-3:0]     out_m;
  logic [SW-1:0]     out_scale;
  logic              out_zf;
  logic              out_sat;
  logic [TAG_W-1:0]  out_tag;
  logic [15:0]       sat_count;

  modport master (
    output in_valid, in_sub, in_scale, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_m, out_scale, out_zf, out_sat, out_tag, sat_count
  );

  modport slave (
    input  in_valid, in_sub, in_scale, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_m, out_scale, out_zf, out_sat, out_tag, sat_count
  );
endinterface
`default_nettype wire

// File: rtl/posit_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : posit_norm_pipe
// Brief    : Two-stage valid/ready posit mantissa normaliser with scale clamp.
// Revision : 1.0 - initial release
// ============================================================================
module posit_norm_pipe #(
  parameter int N     = 16,
  parameter int ES    = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  posit_norm_pipe_if.slave bus
);
  localparam int BS  = $clog2(N);
  localparam int MW  = N - ES + 4;
  localparam int SW  = BS + ES + 1;
  localparam int XW  = SW + 2;
  localparam int LZW = $clog2(MW - 1);
  localparam logic signed [XW-1:0] C_SMAX = XW'((N - 1) * (2 ** ES));
  localparam logic signed [XW-1:0] C_SMIN = XW'(-N * (2 ** ES));

  logic w_s1_adv, w_s2_adv;
  logic r_s1_valid, r_s2_valid;

  logic              r_s1_sub, r_s1_carry, r_s1_zero;
  logic [SW-1:0]     r_s1_scale;
  logic [MW-2:0]     r_s1_c;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [LZW-1:0]    r_s1_lz;

  logic [MW-3:0]     r_s2_m;
  logic [SW-1:0]     r_s2_scale;
  logic              r_s2_zf, r_s2_sat;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [15:0]       r_sat_count;

  logic [LZW-1:0]    w_lz;
  logic              w_zero;
  logic              w_unused_msb;

  logic signed [XW-1:0] w_scale_ext, w_scale_adj;
  logic [MW-3:0]        w_m;
  logic [SW-1:0]        w_scale_out;
  logic                 w_zf, w_sat;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign w_unused_msb = bus.in_c[MW-1];

  // Ascending scan: the highest set bit is the last to write, giving the lz.
  always_comb begin
    w_lz   = '0;
    w_zero = (bus.in_c[MW-3:0] == '0);
    for (int i = 0; i <= MW - 3; i++) begin
      if (bus.in_c[i]) w_lz = LZW'(MW - 3 - i);
    end
  end

  always_comb begin
    w_scale_ext = {{2{r_s1_scale[SW-1]}}, r_s1_scale};
    w_scale_adj = w_scale_ext;
    w_m         = r_s1_c[MW-3:0];
    w_zf        = 1'b0;
    w_sat       = 1'b0;
    w_scale_out = '0;
    if (!r_s1_sub) begin
      if (r_s1_carry) begin
        // Carry shifts right one place; the dropped LSB is folded in as sticky.
        w_m         = {r_s1_c[MW-2:2], r_s1_c[1] | r_s1_c[0]};
        w_scale_adj = w_scale_ext + XW'(1);
      end
    end else begin
      w_m         = r_s1_c[MW-3:0] << r_s1_lz;
      w_scale_adj = w_scale_ext - XW'(r_s1_lz);
    end
    if (r_s1_sub && r_s1_zero) begin
      w_zf = 1'b1;
      w_m  = '0;
    end else if (w_scale_adj > C_SMAX) begin
      w_scale_out = C_SMAX[SW-1:0];
      w_m         = '0;
      w_sat       = 1'b1;
    end else if (w_scale_adj < C_SMIN) begin
      w_scale_out = C_SMIN[SW-1:0];
      w_m         = '0;
      w_sat       = 1'b1;
    end else begin
      w_scale_out = w_scale_adj[SW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sub    <= 1'b0;
      r_s1_carry  <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_scale  <= '0;
      r_s1_c      <= '0;
      r_s1_tag    <= '0;
      r_s1_lz     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_m      <= '0;
      r_s2_scale  <= '0;
      r_s2_zf     <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_s2_tag    <= '0;
      r_sat_count <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sub   <= bus.in_sub;
          r_s1_carry <= bus.in_c[MW-2];
          r_s1_zero  <= w_zero;
          r_s1_scale <= bus.in_scale;
          r_s1_c     <= bus.in_c[MW-2:0];
          r_s1_tag   <= bus.in_tag;
          r_s1_lz    <= w_lz;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_m     <= w_m;
          r_s2_scale <= w_scale_out;
          r_s2_zf    <= w_zf;
          r_s2_sat   <= w_sat;
          r_s2_tag   <= r_s1_tag;
        end
      end
      if (r_s2_valid && bus.out_ready && r_s2_sat && (r_sat_count != 16'hFFFF))
        r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_m     = r_s2_m;
  assign bus.out_scale = r_s2_scale;
  assign bus.out_zf    = r_s2_zf;
  assign bus.out_sat   = r_s2_sat;
  assign bus.out_tag   = r_s2_tag;
  assign bus.sat_count = r_sat_count;
endmodule
`default_nettype wire
